reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter SP_INIT, default 32'd128: reset value of register 29 (stack pointer).
REQ-002 Parameter SP_IDX, default 5'd29: index of the register that takes SP_INIT at reset.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 rs_addr_i  input  5  read port A address (instruction rs field).
REQ-006 rt_addr_i  input  5  read port B address (instruction rt field).
REQ-007 rd_addr_i  input  5  write port address (rd or rt, selected upstream).
REQ-008 rd_data_i  input  32  write data (ALU result or load data).
REQ-009 reg_write_i  input  1  write enable, sampled at rising clk_i.
REQ-010 rs_data_o  output  32  read port A data; drives ALU src1_i.
REQ-011 rt_data_o  output  32  read port B data; drives ALU src2_i (via mux).

Function
REQ-012 Storage SHALL be 32 entries x 32 bits, signed interpretation left to consumers.
REQ-013 Reads SHALL be combinational: rs_data_o/rt_data_o follow address changes with zero clock latency.
REQ-014 Write SHALL occur at rising clk_i when reg_write_i=1 and rst_i=0: entry[rd_addr_i] <= rd_data_i, visible on reads from the next cycle.
REQ-015 Entry 0 SHALL always read 32'd0; writes to address 0 SHALL be discarded.
REQ-016 reg_write_i=0 SHALL leave all entries unchanged regardless of rd_addr_i/rd_data_i.
REQ-017 Both read ports SHALL operate independently; rs_addr_i==rt_addr_i SHALL return identical data on both.
REQ-018 Same-cycle read and write of one address (non-bypass build) SHALL return the old value until the clock edge.
REQ-019 Exactly one entry SHALL change per write edge; no other entry disturbed.
REQ-020 Write of SP_IDX SHALL overwrite SP_INIT normally; no protection.

Reset
REQ-021 rst_i=1 SHALL immediately, without clock, set every entry to 32'd0 except entry SP_IDX = SP_INIT.
REQ-022 While rst_i=1, writes SHALL be ignored; outputs reflect reset contents combinationally.
REQ-023 Reset asserted mid-write cycle SHALL win: the pending write is lost.
REQ-024 After rst_i deasserts, first write SHALL take effect on the first rising clk_i with rst_i=0.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN SHALL, when defined, forward rd_data_i to a read port in the same cycle when reg_write_i=1, rst_i=0, rd_addr_i!=0 and rd_addr_i equals that port's address.
REQ-026 Without REG_FILE_BYPASS_EN, reads SHALL return stored contents only (REQ-018 behaviour).
REQ-027 Bypass SHALL never apply to address 0 nor while rst_i=1.

Verification
REQ-028 Pulse rst_i, read all 32 addresses -> 0 everywhere except address 29 = 32'd128.
REQ-029 Write 32'hDEADBEEF to addr 5, then read rs=5, rt=5 -> both 32'hDEADBEEF next cycle; addr 6 still 0.
REQ-030 Write 32'hFFFFFFFF to addr 0 -> rs_data_o for addr 0 stays 32'd0.
REQ-031 reg_write_i=0 with rd_addr_i=7, rd_data_i=32'h1234 -> addr 7 remains 0.
REQ-032 Same-cycle write 32'h55 to addr 3 with rs_addr_i=3 -> pre-edge reads old 0 (no macro) or 32'h55 (REG_FILE_BYPASS_EN).
REQ-033 Assert rst_i asynchronously between edges after writing addr 10=32'hA -> addr 10 reads 0 immediately, before next edge.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports, one write port, async reset.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file #(
  parameter logic [31:0] SP_INIT = 32'd128,
  parameter logic [4:0]  SP_IDX  = 5'd29
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        reg_write_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o
);
  logic [31:0] regs [32];
  logic        byp_rs, byp_rt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)
      for (int i = 0; i < 32; i++) regs[i] <= (5'(i) == SP_IDX && i != 0) ? SP_INIT : '0;
    else if (reg_write_i && rd_addr_i != 5'd0)
      regs[rd_addr_i] <= rd_data_i;
`ifdef REG_FILE_BYPASS_EN
  assign byp_rs = reg_write_i && !rst_i && rd_addr_i == rs_addr_i;
  assign byp_rt = reg_write_i && !rst_i && rd_addr_i == rt_addr_i;
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif
  // Address 0 is forced to zero here, which also excludes it from forwarding.
  assign rs_data_o = rs_addr_i == 5'd0 ? '0 : byp_rs ? rd_data_i : regs[rs_addr_i];
  assign rt_data_o = rt_addr_i == 5'd0 ? '0 : byp_rt ? rd_data_i : regs[rt_addr_i];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table-driven bench for reg_file plus reset/forwarding sequences.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] rs_data, rt_data;
  int          checks = 0;
  int          errors = 0;

  reg_file dut (
    .clk_i(clk), .rst_i(rst),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .reg_write_i(reg_write),
    .rs_data_o(rs_data), .rt_data_o(rt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ers;
    logic [31:0] ert;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] rs, input logic [4:0] rt);
    reg_write = we; rd_addr = rd; rd_data = d; rs_addr = rs; rt_addr = rt;
  endtask

  initial begin
    // Each row: inputs applied after a falling edge, reads checked before the next rising edge.
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd29, 32'h0,        32'd128};
    tbl[1] = '{1'b0, 5'd7,  32'h00001234, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd6,  32'h0,        32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd29, 32'h00001000, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd29, 5'd30, 32'h00001000, 32'h0};
    tbl[6] = '{1'b1, 5'd30, 32'h12345678, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h0};
    tbl[7] = '{1'b0, 5'd31, 32'h0,        5'd30, 5'd31, 32'h12345678, 32'hA5A5A5A5};
    tbl[8] = '{1'b1, 5'd5,  32'h00000001, 5'd31, 5'd29, 32'hA5A5A5A5, 32'h00001000};
    tbl[9] = '{1'b0, 5'd6,  32'h0,        5'd5,  5'd6,  32'h00000001, 32'h0};

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      #1;
      chk("reset_rs", rs_data, a == 29 ? 32'd128 : 32'd0);
      chk("reset_rt", rt_data, (31 - a) == 29 ? 32'd128 : 32'd0);
    end
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].rd, tbl[i].d, tbl[i].rs, tbl[i].rt);
      #1;
      chk($sformatf("vec%0d_rs", i), rs_data, tbl[i].ers);
      chk($sformatf("vec%0d_rt", i), rt_data, tbl[i].ert);
    end

    // Same-cycle write and read of one address
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h55, 5'd3, 5'd4);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("same_cycle_pre_edge", rs_data, 32'h55);
`else
    chk("same_cycle_pre_edge", rs_data, 32'h0);
`endif
    chk("same_cycle_other_port", rt_data, 32'h0);
    @(posedge clk) #1 reg_write = 1'b0;
    chk("same_cycle_post_edge", rs_data, 32'h55);

    // Asynchronous reset between edges clears contents immediately
    @(negedge clk);
    drive(1'b1, 5'd10, 32'hA, 5'd10, 5'd29);
    @(posedge clk) #1 reg_write = 1'b0;
    chk("addr10_written", rs_data, 32'hA);
    chk("sp_before_reset", rt_data, 32'h00001000);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_addr10", rs_data, 32'h0);
    chk("async_reset_sp", rt_data, 32'd128);

    // Writes during reset are lost
    drive(1'b1, 5'd12, 32'h77, 5'd12, 5'd3);
    @(posedge clk) #1;
    chk("write_during_reset", rs_data, 32'h0);
    chk("addr3_cleared", rt_data, 32'h0);

    // First edge after release takes the write
    @(negedge clk) rst = 1'b0;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("post_reset_pre_edge", rs_data, 32'h77);
`else
    chk("post_reset_pre_edge", rs_data, 32'h0);
`endif
    @(posedge clk) #1 reg_write = 1'b0;
    chk("post_reset_first_write", rs_data, 32'h77);
    rs_addr = 5'd29;
    #1;
    chk("sp_after_reset", rs_data, 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
